pipe_ctrl: RTL and testbench

Central pipeline controller for the five-stage MIPS core. It merges per-stage stall requests into the six-bit `stall` vector consumed by the PC register and every inter-stage register, and it raises a one-cycle `flush` with a redirect PC on exception or ERET. It also tracks in-flight instruction-fetch requests so that wrong-path fetch responses arriving after a flush are marked for discard. It sits beside the datapath and drives the control inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_ctrl_inst_track.sv | 67 ++++++
 rtl/pipe_ctrl.sv | 71 +++++++
 tb/tb_pipe_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and the fetch-tracking state type for the pipeline controller.
package pipe_ctrl_pkg;

  // One bit per stage: bit0 PC ... bit5 WB; a stalling stage also holds every stage before it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  typedef enum logic [0:0] {
    PC_RUN   = 1'b0,
    PC_DRAIN = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_inst_track.sv
// Tracks in-flight instruction fetches and marks responses that belong to the
// path abandoned by a flush.
module inst_track
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  input  logic inst_req_fire,
  input  logic inst_data_ok,
  output logic inst_discard,
  output logic inst_req_allow
);

  logic [1:0] outst_reg, outst_next;
  logic [1:0] disc_reg, disc_next;
  pc_state_e  state_reg, state_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outst_reg <= 2'd0;
      disc_reg  <= 2'd0;
      state_reg <= PC_RUN;
    end else begin
      outst_reg <= outst_next;
      disc_reg  <= disc_next;
      state_reg <= state_next;
    end
  end

  always_comb begin
    outst_next = outst_reg;
    if (inst_req_fire && !inst_data_ok && outst_reg != 2'd3)
      outst_next = outst_reg + 2'd1;
    else if (!inst_req_fire && inst_data_ok && outst_reg != 2'd0)
      outst_next = outst_reg - 2'd1;
  end

  // Every request still in flight after the flush edge, including one issued in
  // the flush cycle itself, fetched from the wrong path.
  always_comb begin
    disc_next = disc_reg;
    if (flush)
      disc_next = outst_next;
    else if (inst_data_ok && disc_reg != 2'd0)
      disc_next = disc_reg - 2'd1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PC_RUN: begin
        if (flush && outst_next != 2'd0)
          state_next = PC_DRAIN;
      end
      PC_DRAIN: begin
        if (!flush && disc_next == 2'd0)
          state_next = PC_RUN;
      end
      default: state_next = PC_RUN;
    endcase
  end

  assign inst_discard   = rstn && inst_data_ok && (disc_reg != 2'd0 || flush);
  assign inst_req_allow = rstn && (outst_reg != 2'd3);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, raises flush/redirect on
// exception or ERET, and counts stalled cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        exc_valid,
  input  logic        exc_eret,
  input  logic [31:0] epc_in,
  input  logic        inst_req_fire,
  input  logic        inst_data_ok,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        inst_discard,
  output logic        inst_req_allow,
  output logic [31:0] stall_cycles
);

  logic [5:0]  stall_req;
  logic [31:0] stall_cycles_reg;

  always_comb begin
    stall_req = STALL_NONE;
    if (stallreq_mem)
      stall_req = STALL_MEM;
    else if (stallreq_ex)
      stall_req = STALL_EX;
    else if (stallreq_id)
      stall_req = STALL_ID;
    else if (stallreq_if)
      stall_req = STALL_IF;
  end

  // A committed exception squashes everything, so it overrides any stall request.
  always_comb begin
    flush  = 1'b0;
    stall  = STALL_NONE;
    new_pc = RESET_PC;
    if (rstn) begin
      flush  = exc_valid;
      stall  = exc_valid ? STALL_NONE : stall_req;
      new_pc = (exc_valid && exc_eret) ? epc_in : EXC_VECTOR;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cycles_reg <= 32'd0;
    else if (stall != STALL_NONE)
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
  end

  assign stall_cycles = stall_cycles_reg;

  inst_track u_track (
    .clk            (clk),
    .rstn           (rstn),
    .flush          (flush),
    .inst_req_fire  (inst_req_fire),
    .inst_data_ok   (inst_data_ok),
    .inst_discard   (inst_discard),
    .inst_req_allow (inst_req_allow)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for stall/flush muxing plus
// hand-written fetch-tracking and reset sequences.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        exc_valid, exc_eret;
  logic [31:0] epc_in;
  logic        inst_req_fire, inst_data_ok;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        inst_discard, inst_req_allow;
  logic [31:0] stall_cycles;

  int passed = 0;
  int total  = 0;
  int exp_cycles = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .stallreq_if    (stallreq_if),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .stallreq_mem   (stallreq_mem),
    .exc_valid      (exc_valid),
    .exc_eret       (exc_eret),
    .epc_in         (epc_in),
    .inst_req_fire  (inst_req_fire),
    .inst_data_ok   (inst_data_ok),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .inst_discard   (inst_discard),
    .inst_req_allow (inst_req_allow),
    .stall_cycles   (stall_cycles)
  );

  // Firing a request with three already outstanding is a fetch-unit bug.
  always @(posedge clk) begin
    if (rstn === 1'b1 && inst_req_fire === 1'b1)
      assert (inst_req_allow === 1'b1) else $error("illegal inst_req_fire with outst=3");
  end

  typedef struct {
    logic [3:0]  req;    // {mem, ex, id, if}
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic [5:0]  exp_stall;
    logic        exp_flush;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic fire, input logic ok, input logic exc,
                       input logic eret, input logic [31:0] epc);
    inst_req_fire = fire;
    inst_data_ok  = ok;
    exc_valid     = exc;
    exc_eret      = eret;
    epc_in        = epc;
  endtask

  function automatic logic [31:0] st();
    return {31'd0, dut.u_track.state_reg};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0]  = '{4'b0000, 1'b0, 1'b0, 32'h0,         6'b000000, 1'b0, EXC_VECTOR};
    vecs[1]  = '{4'b0001, 1'b0, 1'b0, 32'h0,         6'b000011, 1'b0, EXC_VECTOR};
    vecs[2]  = '{4'b0010, 1'b0, 1'b0, 32'h0,         6'b000111, 1'b0, EXC_VECTOR};
    vecs[3]  = '{4'b0100, 1'b0, 1'b0, 32'h0,         6'b001111, 1'b0, EXC_VECTOR};
    vecs[4]  = '{4'b1000, 1'b0, 1'b0, 32'h0,         6'b011111, 1'b0, EXC_VECTOR};
    vecs[5]  = '{4'b0110, 1'b0, 1'b0, 32'h0,         6'b001111, 1'b0, EXC_VECTOR};
    vecs[6]  = '{4'b1110, 1'b0, 1'b0, 32'h0,         6'b011111, 1'b0, EXC_VECTOR};
    vecs[7]  = '{4'b1111, 1'b0, 1'b0, 32'h0,         6'b011111, 1'b0, EXC_VECTOR};
    vecs[8]  = '{4'b0011, 1'b0, 1'b0, 32'h0,         6'b000111, 1'b0, EXC_VECTOR};
    vecs[9]  = '{4'b1000, 1'b1, 1'b0, 32'h1111_2222, 6'b000000, 1'b1, 32'hBFC0_0380};
    vecs[10] = '{4'b0000, 1'b1, 1'b1, 32'h8000_1234, 6'b000000, 1'b1, 32'h8000_1234};
    vecs[11] = '{4'b1111, 1'b1, 1'b1, 32'hDEAD_BEE0, 6'b000000, 1'b1, 32'hDEAD_BEE0};
    vecs[12] = '{4'b0000, 1'b0, 1'b1, 32'h1234_5678, 6'b000000, 1'b0, 32'hBFC0_0380};

    // Reset with hostile inputs: outputs must sit at their reset values.
    rstn = 1'b0;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b1000;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0000);
    step();
    step();
    $display("reset: stall=%b flush=%b new_pc=%h", stall, flush, new_pc);
    check("rst_stall", {26'd0, stall}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_new_pc", new_pc, RESET_PC);
    check("rst_discard", {31'd0, inst_discard}, 32'd0);
    check("rst_allow", {31'd0, inst_req_allow}, 32'd0);
    check("rst_cycles", stall_cycles, 32'd0);
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rstn = 1'b1;
    #1;
    check("post_rst_allow", {31'd0, inst_req_allow}, 32'd1);
    step();

    for (int i = 0; i < 13; i++) begin
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = vecs[i].req;
      drive(1'b0, 1'b0, vecs[i].exc, vecs[i].eret, vecs[i].epc);
      #1;
      $display("vec %0d: req=%b exc=%b eret=%b stall=%b flush=%b new_pc=%h cycles=%0d",
               i, vecs[i].req, vecs[i].exc, vecs[i].eret, stall, flush, new_pc, stall_cycles);
      check($sformatf("vec%0d_stall", i), {26'd0, stall}, {26'd0, vecs[i].exp_stall});
      check($sformatf("vec%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].exp_flush});
      check($sformatf("vec%0d_new_pc", i), new_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_cycles", i), stall_cycles, exp_cycles);
      if (vecs[i].exp_stall != 6'd0) exp_cycles++;
      step();
    end
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("table_cycles_final", stall_cycles, exp_cycles);
    check("table_state_run", st(), 32'd0);

    // Two requests in flight, then flush: both responses are wrong-path.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); step();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); #1;
    $display("seqA flush: flush=%b discard=%b", flush, inst_discard);
    check("seqA_flush", {31'd0, flush}, 32'd1);
    check("seqA_flush_discard", {31'd0, inst_discard}, 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("seqA_flush_one_cycle", {31'd0, flush}, 32'd0);
    check("seqA_state_drain", st(), 32'd1);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0); #1;
      $display("seqA resp %0d: discard=%b", k, inst_discard);
      check($sformatf("seqA_resp%0d_discard", k), {31'd0, inst_discard}, 32'd1);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("seqA_state_run", st(), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0); #1;
    $display("seqA resp 2: discard=%b", inst_discard);
    check("seqA_resp2_keep", {31'd0, inst_discard}, 32'd0);
    step();

    // Three outstanding blocks further requests until one returns.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); #1;
      check($sformatf("seqB_allow%0d", k), {31'd0, inst_req_allow}, 32'd1);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    $display("seqB full: allow=%b", inst_req_allow);
    check("seqB_full_block", {31'd0, inst_req_allow}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0); #1;
    check("seqB_resp_keep", {31'd0, inst_discard}, 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("seqB_reopen", {31'd0, inst_req_allow}, 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0); step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0); step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Flush cycle with a request and a response together.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0); #1;
    $display("seqC flush+fire+ok: flush=%b discard=%b", flush, inst_discard);
    check("seqC_same_cycle_discard", {31'd0, inst_discard}, 32'd1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("seqC_state_drain", st(), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0); #1;
    check("seqC_late_discard", {31'd0, inst_discard}, 32'd1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("seqC_state_run", st(), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0); #1;
    check("seqC_resp_keep", {31'd0, inst_discard}, 32'd0);
    step();

    // Reset arriving while draining two wrong-path responses.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); step();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0); step();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    stallreq_mem = 1'b1;
    #1;
    check("seqD_pre_discard", {31'd0, inst_discard}, 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    $display("seqD reset: stall=%b flush=%b new_pc=%h discard=%b allow=%b",
             stall, flush, new_pc, inst_discard, inst_req_allow);
    check("seqD_stall", {26'd0, stall}, 32'd0);
    check("seqD_flush", {31'd0, flush}, 32'd0);
    check("seqD_new_pc", new_pc, RESET_PC);
    check("seqD_discard", {31'd0, inst_discard}, 32'd0);
    check("seqD_allow", {31'd0, inst_req_allow}, 32'd0);
    check("seqD_state_run", st(), 32'd0);
    check("seqD_cycles", stall_cycles, 32'd0);
    stallreq_mem = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    rstn = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0); #1;
    $display("seqD after reset: discard=%b", inst_discard);
    check("seqD_resp_keep", {31'd0, inst_discard}, 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("seqD_final_cycles", stall_cycles, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
